// File: rtl/mxn_pkg.sv
// mxn_pkg
// Shared definitions for the MxN serializer slice.
//   MXN_M_DEFAULT / MXN_N_DEFAULT : default beat width and beats per word
//   mxn_state_e                   : serializer FSM state (IDLE, SHIFT)
//   mxn_cnt_width(n)              : beat counter width, max(1, $clog2(n))
package mxn_pkg;

  localparam int unsigned MXN_M_DEFAULT = 3;
  localparam int unsigned MXN_N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } mxn_state_e;

  function automatic int unsigned mxn_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mxn_beat_mux.sv
// mxn_beat_mux
// Combinational N:1 selector picking one M-bit slot of a held word by beat index.
// Configuration macro: MXN_SERIALIZER_MSB_FIRST_EN -- when defined, beat index 0
// selects slot N-1 (MSB-first); otherwise beat index 0 selects slot 0.
// Ports:
//   word_i [M*N] : held parallel word, slot k = word_i[M*k +: M]
//   sel_i  [CW]  : beat index 0..N-1
//   beat_o [M]   : selected slot
module mxn_beat_mux
  import mxn_pkg::*;
#(
  parameter int unsigned M  = MXN_M_DEFAULT,
  parameter int unsigned N  = MXN_N_DEFAULT,
  parameter int unsigned CW = mxn_cnt_width(N)
) (
  input  logic [M*N-1:0] word_i,
  input  logic [CW-1:0]  sel_i,
  output logic [M-1:0]   beat_o
);

  always_comb begin
    beat_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
`ifdef MXN_SERIALIZER_MSB_FIRST_EN
      // Beat index counts down the slots: beat 0 is slot N-1.
      if (sel_i == CW'(N - 1 - k)) beat_o = word_i[M*k +: M];
`else
      if (sel_i == CW'(k)) beat_o = word_i[M*k +: M];
`endif
    end
  end

endmodule

// File: rtl/mxn_serializer.sv
// mxn_serializer
// Parallel-in, serial-out: accepts one N x M-bit word and emits it as N
// consecutive M-bit beats on a valid/ready stream. A new word can be accepted
// on the same edge as the final beat, so back-to-back words have no bubble.
// Configuration macro: MXN_SERIALIZER_MSB_FIRST_EN -- slot N-1 first when
// defined, slot 0 first otherwise. out_last always marks the final beat.
// Ports:
//   clk       : clock, all state on posedge
//   rst_n     : synchronous active-low reset
//   in_data   : parallel word [M*N], slot k = in_data[M*k +: M]
//   in_valid  : word present
//   in_ready  : word accepted on posedge when in_valid & in_ready
//   out_data  : current beat [M]
//   out_valid : beat present
//   out_ready : beat consumed on posedge when out_valid & out_ready
//   out_last  : final beat of a word
module mxn_serializer
  import mxn_pkg::*;
#(
  parameter int unsigned M = MXN_M_DEFAULT,
  parameter int unsigned N = MXN_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last
);

  localparam int unsigned   CW   = mxn_cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mxn_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M*N-1:0] hold_q, hold_d;
  logic           is_last;
  logic [M-1:0]   beat;

  assign is_last = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          hold_d  = in_data;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (!is_last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (in_valid) begin
            // Final beat and next word handshake on the same edge.
            cnt_d  = '0;
            hold_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mxn_beat_mux #(
    .M  (M),
    .N  (N),
    .CW (CW)
  ) u_beat_mux (
    .word_i (hold_q),
    .sel_i  (cnt_q),
    .beat_o (beat)
  );

  // Outputs; in_ready depends combinationally on out_ready so the next word
  // can be taken on the final-beat edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        in_ready  = out_ready & is_last;
        out_valid = 1'b1;
        out_last  = is_last;
        out_data  = beat;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mxn_serializer.sv
module tb_mxn_serializer;

  typedef struct {
    logic [11:0]     word;
    logic [3:0][2:0] slot;
  } vec_t;

  typedef struct packed {
    logic [2:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid, in_ready;
  logic [2:0]  out_data;
  logic        out_valid, out_ready, out_last;

  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready, b_out_last;

  mxn_serializer #(.M(3), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  mxn_serializer #(.M(8), .N(1)) u_n1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_last  (b_out_last)
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    npop = 0;
  int    first_pop = -1;
  int    last_pop = -1;
  vec_t  vec [6];
  beat_t sb [$];
  logic [7:0] n1_words [3];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for a word, in emission order.
  task automatic push_word(input int vi);
    int k;
    for (int i = 0; i < 4; i++) begin
`ifdef MXN_SERIALIZER_MSB_FIRST_EN
      k = 3 - i;
`else
      k = i;
`endif
      sb.push_back('{data: vec[vi].slot[k], last: (i == 3)});
    end
  endtask

  // Scoreboard: pop and compare every consumed beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %0h with no beat expected (cycle %0d)", out_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_last", out_last, e.last);
        chk("in_ready_on_beat", in_ready, e.last);
        npop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic send(input int vi, input bit keep);
    int budget;
    bit acc;
    budget   = 50;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = vec[vi].word;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) push_word(vi);
      tick();
      budget--;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no in_ready expected accept of %0h", vec[vi].word);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_remaining", sb.size(), 0);
    @(negedge clk);
    chk("idle_out_valid", out_valid, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0].word = 12'hABC; vec[0].slot = {3'd5, 3'd2, 3'd7, 3'd4};
    vec[1].word = 12'h123; vec[1].slot = {3'd0, 3'd4, 3'd4, 3'd3};
    vec[2].word = 12'hFFF; vec[2].slot = {3'd7, 3'd7, 3'd7, 3'd7};
    vec[3].word = 12'h000; vec[3].slot = {3'd0, 3'd0, 3'd0, 3'd0};
    vec[4].word = 12'h0F0; vec[4].slot = {3'd0, 3'd3, 3'd6, 3'd0};
    vec[5].word = 12'hFAC; vec[5].slot = {3'd7, 3'd6, 3'd5, 3'd4};
    n1_words[0] = 8'h11;
    n1_words[1] = 8'h22;
    n1_words[2] = 8'h33;

    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_n1_out_valid", b_out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table: one word at a time, consumer always ready
    for (int i = 0; i < 6; i++) begin
      send(i, 1'b0);
      @(negedge clk);
      chk("latency_valid", out_valid, 1'b1);
      drain();
    end

    // Back-to-back words: eight beats in eight consecutive cycles
    npop      = 0;
    first_pop = -1;
    send(0, 1'b1);
    send(1, 1'b0);
    drain();
    chk("b2b_beats", npop, 8);
    chk("b2b_span", last_pop - first_pop, 7);

    // Backpressure on the second beat
    send(0, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 3'd7);
      chk("stall_last", out_last, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Reset after the second beat is consumed; remainder discarded
    send(0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_out_last", out_last, 1'b0);
    tick();
    send(2, 1'b0);
    drain();

    // N=1, M=8: one beat per cycle, each marked last
    b_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = n1_words[i];
      @(negedge clk);
      chk("n1_in_ready", b_in_ready, 1'b1);
      if (i > 0) begin
        chk("n1_valid", b_out_valid, 1'b1);
        chk("n1_data", b_out_data, n1_words[i-1]);
        chk("n1_last", b_out_last, 1'b1);
      end
      tick();
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("n1_valid", b_out_valid, 1'b1);
    chk("n1_data", b_out_data, n1_words[2]);
    chk("n1_last", b_out_last, 1'b1);
    tick();
    @(negedge clk);
    chk("n1_idle_valid", b_out_valid, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
